// File: rtl/flag_bank.sv
// Status-flag register file with per-flag load/set/clear and a LIFO of flag
// snapshots for nested interrupts. Optional: FLAG_BANK_SAVE_CLR_EN clears flags on save.
module flag_bank #(
  parameter int NUM_FLAGS    = 2,
  parameter int SHADOW_DEPTH = 4,
  parameter int DW           = $clog2(SHADOW_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FLAGS-1:0] flg_wr_en,
  input  logic [NUM_FLAGS-1:0] flg_din,
  input  logic [NUM_FLAGS-1:0] flg_set,
  input  logic [NUM_FLAGS-1:0] flg_clr,
  input  logic                 save,
  input  logic                 restore,
  input  logic                 err_clr,
  output logic [NUM_FLAGS-1:0] flags_out,
  output logic [DW-1:0]        depth,
  output logic                 shadow_full,
  output logic                 shadow_empty,
  output logic                 ovf_err,
  output logic                 unf_err
);

  localparam int AW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(SHADOW_DEPTH);
`ifdef FLAG_BANK_SAVE_CLR_EN
  localparam bit SAVE_CLR = 1'b1;
`else
  localparam bit SAVE_CLR = 1'b0;
`endif

  logic [NUM_FLAGS-1:0] flags_reg, flags_next, ctrl_next, top_snap;
  logic [DW-1:0]        depth_reg, depth_next;
  logic                 ovf_reg, ovf_next, unf_reg, unf_next;
  logic [NUM_FLAGS-1:0] shadow_mem [SHADOW_DEPTH];
  logic [AW-1:0]        push_idx, top_idx;
  logic                 is_empty, is_full;
  logic                 do_pop, do_swap, do_push, ovf_set, unf_set;

  assign is_empty = (depth_reg == '0);
  assign is_full  = (depth_reg == FULL_DEPTH);
  assign push_idx = AW'(depth_reg);
  assign top_idx  = AW'(depth_reg - DW'(1));
  assign top_snap = shadow_mem[top_idx];

  // save+restore with entries present is a swap; with none it degrades to a push
  assign do_swap = save && restore && !is_empty;
  assign do_pop  = restore && !save && !is_empty;
  assign do_push = save && !do_swap && !is_full;
  assign ovf_set = save && !restore && is_full;
  assign unf_set = restore && !save && is_empty;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
      always_comb begin
        ctrl_next[gi] = flags_reg[gi];
        if (flg_clr[gi])        ctrl_next[gi] = 1'b0;
        else if (flg_set[gi])   ctrl_next[gi] = 1'b1;
        else if (flg_wr_en[gi]) ctrl_next[gi] = flg_din[gi];
      end
    end
  endgenerate

  always_comb begin
    flags_next = ctrl_next;
    if (do_pop || do_swap)       flags_next = top_snap;
    else if (SAVE_CLR && do_push) flags_next = '0;

    depth_next = depth_reg;
    if (do_push)     depth_next = depth_reg + DW'(1);
    else if (do_pop) depth_next = depth_reg - DW'(1);

    ovf_next = ovf_set || (ovf_reg && !err_clr);
    unf_next = unf_set || (unf_reg && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Snapshot storage needs no reset; its contents are meaningless when depth is 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push)      shadow_mem[push_idx] <= flags_reg;
      else if (do_swap) shadow_mem[top_idx]  <= flags_reg;
    end
  end

  assign flags_out    = flags_reg;
  assign depth        = depth_reg;
  assign shadow_full  = is_full;
  assign shadow_empty = is_empty;
  assign ovf_err      = ovf_reg;
  assign unf_err      = unf_reg;

endmodule

// File: tb/tb_flag_bank.sv
// Directed bench for flag_bank: expected results are queued per step and
// checked one cycle later. Honours FLAG_BANK_SAVE_CLR_EN when defined.
module tb_flag_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] flg_wr_en, flg_din, flg_set, flg_clr;
  logic       save, restore, err_clr;
  logic [1:0] flags_out;
  logic [2:0] depth;
  logic       shadow_full, shadow_empty, ovf_err, unf_err;

`ifdef FLAG_BANK_SAVE_CLR_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [1:0] f;
    logic [2:0] d;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  flag_bank #(.NUM_FLAGS(2), .SHADOW_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .flg_wr_en(flg_wr_en), .flg_din(flg_din), .flg_set(flg_set), .flg_clr(flg_clr),
    .save(save), .restore(restore), .err_clr(err_clr),
    .flags_out(flags_out), .depth(depth),
    .shadow_full(shadow_full), .shadow_empty(shadow_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] we, din, st, cl,
                      input logic sv, rs, ec, rst,
                      input logic [1:0] ef, input int ed, input logic eo, eu);
    exp_t e;
    exp_t got;
    flg_wr_en = we; flg_din = din; flg_set = st; flg_clr = cl;
    save = sv; restore = rs; err_clr = ec; reset = rst;
    e.tag = tag; e.f = ef; e.d = 3'(ed);
    e.full = (ed == 4); e.empty = (ed == 0); e.ovf = eo; e.unf = eu;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "flags", {2'b00, flags_out}, {2'b00, got.f});
    chk(got.tag, "depth", {1'b0, depth}, {1'b0, got.d});
    chk(got.tag, "full",  {3'b000, shadow_full}, {3'b000, got.full});
    chk(got.tag, "empty", {3'b000, shadow_empty}, {3'b000, got.empty});
    chk(got.tag, "ovf",   {3'b000, ovf_err}, {3'b000, got.ovf});
    chk(got.tag, "unf",   {3'b000, unf_err}, {3'b000, got.unf});
    $display("step %-10s flags=%b depth=%0d full=%b empty=%b ovf=%b unf=%b",
             got.tag, flags_out, depth, shadow_full, shadow_empty, ovf_err, unf_err);
  endtask

  initial begin
    reset = 1'b1; flg_wr_en = '0; flg_din = '0; flg_set = '0; flg_clr = '0;
    save = 1'b0; restore = 1'b0; err_clr = 1'b0;
    #1;
    //     tag          we     din    set    clr    sv rs ec rst  flags               d  ovf unf
    step("reset",     2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00,               0, 0, 0);
    step("set11",     2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11,               0, 0, 0);
    step("clr_win",   2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0, 2'b10,               0, 0, 0);
    step("clr11",     2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00,               0, 0, 0);
    step("set_win",   2'b11, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 2'b11,               0, 0, 0);
    step("load01",    2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01,               0, 0, 0);
    step("save_wr",   2'b11, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b10,  1, 0, 0);
    step("rest1",     2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 0, 0);
    step("push01",    2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b01,  1, 0, 0);
    step("load10",    2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10,               1, 0, 0);
    step("push10",    2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b10,  2, 0, 0);
    step("load11",    2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11,               2, 0, 0);
    step("push11",    2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b11,  3, 0, 0);
    step("load00",    2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00,               3, 0, 0);
    step("push00",    2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00,               4, 0, 0);
    step("ovf",       2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 1, 0, 2'b11,               4, 1, 0);
    step("pop00",     2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00,               3, 1, 0);
    step("pop11",     2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11,               2, 1, 0);
    step("pop10",     2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b10,               1, 1, 0);
    step("pop01",     2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 1, 0);
    step("unf",       2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 1, 1);
    step("errclr",    2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'b01,               0, 0, 0);
    step("unf_win",   2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 2'b01,               0, 0, 1);
    step("errclr2",   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'b01,               0, 0, 0);
    step("ld10",      2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10,               0, 0, 0);
    step("sv10",      2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b10,  1, 0, 0);
    step("ld01",      2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01,               1, 0, 0);
    step("swap",      2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 2'b10,               1, 0, 0);
    step("swap_pop",  2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 0, 0);
    step("sr_empty",  2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, SC ? 2'b00 : 2'b01,  1, 0, 0);
    step("sr_pop",    2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 0, 0);
    step("unf2",      2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01,               0, 0, 1);
    step("fill1",     2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b01,  1, 0, 1);
    step("fill2",     2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b01,  2, 0, 1);
    step("fill3",     2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b01,  3, 0, 1);
    step("rst_mid",   2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 0, 1, 2'b00,               0, 0, 0);
    step("set11b",    2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11,               0, 0, 0);
    step("sv_clr",    2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, SC ? 2'b00 : 2'b11,  1, 0, 0);
    step("rs_clr",    2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11,               0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_bank.md
Name: flag_bank

Overview:
- Parametrised processor status-flag register file: NUM_FLAGS flags (bit 0 = C, bit 1 = Z, higher bits for future flags).
- Each flag has its own load, set and clear controls.
- Includes a SHADOW_DEPTH-entry LIFO of flag snapshots. Interrupt entry pushes a snapshot and interrupt return pops it, so nested interrupts preserve flags.
- Sits between the ALU/control unit and the branch logic.

Parameters:
- NUM_FLAGS, 2, number of flags (1..16).
- SHADOW_DEPTH, 4, number of snapshot entries (1..16).
- DW, $clog2(SHADOW_DEPTH+1), width of the depth count (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flg_wr_en  in  NUM_FLAGS  per-flag load enable.
- flg_din  in  NUM_FLAGS  per-flag load data.
- flg_set  in  NUM_FLAGS  per-flag force to 1.
- flg_clr  in  NUM_FLAGS  per-flag force to 0.
- save  in  1  push the current flags onto the shadow LIFO (interrupt entry).
- restore  in  1  pop the top snapshot into the flags (interrupt return).
- err_clr  in  1  clear the sticky error bits.
- flags_out  out  NUM_FLAGS  current flag values.
- depth  out  DW  number of valid snapshots.
- shadow_full  out  1  depth == SHADOW_DEPTH.
- shadow_empty  out  1  depth == 0.
- ovf_err  out  1  sticky: save attempted while full.
- unf_err  out  1  sticky: restore attempted while empty.

Behaviour:
- Reset (reset=1 at an edge):
  - flags_out=0, depth=0, ovf_err=0, unf_err=0.
  - Shadow contents are don't-care.
  - reset overrides every other input in that cycle, including a save or restore in progress.
- Outputs are registered. Every effect is visible the cycle after the triggering edge (latency 1).
- Per-flag priority, when no restore is performed: flg_clr > flg_set > flg_wr_en > hold.
- Restore performed (restore=1, depth>0, save=0):
  - All flags load the top snapshot, overriding every per-flag control that cycle.
  - depth decrements.
- Save performed (save=1, restore=0, depth<SHADOW_DEPTH):
  - Pushes flags_out as it was before the edge, not the value being written.
  - depth increments.
  - Per-flag controls still apply to the live flags in the same cycle.
- save=1 while full:
  - No push; depth unchanged; shadow unchanged.
  - ovf_err <= 1.
  - Per-flag controls still apply.
- restore=1 while empty:
  - No pop; depth stays 0.
  - unf_err <= 1.
  - Per-flag controls still apply.
- save=1 and restore=1 in the same cycle:
  - depth>0: swap. The flags load the top snapshot and the top entry is overwritten with the pre-edge flags_out. depth unchanged; no error.
  - depth==0: treated as save only. Push occurs, depth becomes 1, unf_err not set.
- err_clr:
  - Clears both sticky bits.
  - If an overflow or underflow occurs in the same cycle, the set wins.
- Storage: the LIFO is a register array indexed by depth. Entry 0 is the oldest snapshot. No wrap-around.
- shadow_full and shadow_empty are combinational decodes of registered depth.

Optional Feature:
- Macro: FLAG_BANK_SAVE_CLR_EN.
- Defined: a performed save (not the full-overflow case, not the swap case) also clears all flags to 0 next cycle, overriding flg_clr, flg_set and flg_wr_en. Interrupt handlers therefore start with clean flags.
- Undefined: a save leaves the live flags under normal per-flag control.

Test Plan:
- Reset, then flg_set=2'b11 for one cycle -> flags_out=2'b11 next cycle. Then flg_set=2'b01 with flg_clr=2'b01 -> flags_out=2'b10 (clr beats set).
- flags=2'b01; save plus flg_wr_en=2'b11, flg_din=2'b10 -> flags_out=2'b10, depth=1. Then restore -> flags_out=2'b01, depth=0, shadow_empty=1.
- Four saves with flags 01, 10, 11, 00 (default depth) -> depth=4, shadow_full=1. Fifth save -> ovf_err=1, depth=4. Four restores -> flags 00, 11, 10, 01 in that order.
- restore at depth=0 -> unf_err=1, flags unchanged. err_clr -> unf_err=0. restore and err_clr together at depth=0 -> unf_err=1.
- depth=1 holding 2'b10, flags=2'b01; save and restore together -> flags_out=2'b10, depth=1. A following restore -> flags_out=2'b01.
- reset asserted mid-sequence at depth=3 -> depth=0, flags_out=0, errors=0 next cycle. With FLAG_BANK_SAVE_CLR_EN defined: flags=2'b11, save -> flags_out=2'b00; restore -> 2'b11.
